// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// default widths and the arbiter FSM state encoding.
package wb_port_arbiter_pkg;

    localparam int DEF_DW        = 16;
    localparam int DEF_AW        = 3;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_arb_fsm.sv
// Round-robin arbiter FSM with capped locked bursts; owns state, last-winner
// and burst counter, and produces the combinational grants and mux select.
module wb_arb_fsm
    import wb_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic lock0,
    input  logic req1,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1,
    output logic sel_next,
    output logic busy
);

    localparam int            CW      = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0_c, gnt1_c, arb_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        arb_c   = 1'b0;
        case (state_q)
            IDLE: arb_c = 1'b1;
            OWN0: begin
                if (req0) begin
                    gnt0_c = 1'b1;
                    cnt_d  = sat_inc(cnt_q);
                    if (!lock0 || (cnt_q == CNT_MAX && req1)) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    arb_c = 1'b1;
                end
            end
            OWN1: begin
                if (req1) begin
                    gnt1_c = 1'b1;
                    cnt_d  = sat_inc(cnt_q);
                    if (!lock1 || (cnt_q == CNT_MAX && req0)) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    arb_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An owner that stops requesting hands the same cycle to normal arbitration.
        if (arb_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (req0 && (!req1 || last_q)) begin
                gnt0_c = 1'b1;
                last_d = 1'b0;
                if (lock0) begin
                    state_d = OWN0;
                    cnt_d   = CNT_ONE;
                end
            end else if (req1) begin
                gnt1_c = 1'b1;
                last_d = 1'b1;
                if (lock1) begin
                    state_d = OWN1;
                    cnt_d   = CNT_ONE;
                end
            end
        end
    end

    assign gnt0     = gnt0_c & rst_n;
    assign gnt1     = gnt1_c & rst_n;
    assign sel_next = gnt1_c;
    assign busy     = (state_q != IDLE);

endmodule : wb_arb_fsm

// File: rtl/wb_port_arbiter.sv
// Two-port arbiter for the shared register-file write port: selects the
// granted port's addr/data and registers them as the write command.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          sel,
    output logic          busy
);

    logic          sel_next;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_data;

    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          sel_q, sel_d;

    wb_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .lock0    (lock0),
        .req1     (req1),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel_next (sel_next),
        .busy     (busy)
    );

    assign mux_addr = sel_next ? addr1 : addr0;
    assign mux_data = sel_next ? data1 : data0;

    // Without a grant only the enable drops; the last command stays visible.
    always_comb begin
        wr_en_d   = gnt0 | gnt1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sel_d     = sel_q;
        if (gnt0 | gnt1) begin
            wr_addr_d = mux_addr;
            wr_data_d = mux_data;
            sel_d     = sel_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign sel     = sel_q;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, ties, single port, forced release,
// owner drop-out and reset in the middle of a burst.
module tb_wb_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, lock0, req1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, wr_en, sel, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .lock0   (lock0),
        .addr0   (addr0),
        .data0   (data0),
        .gnt0    (gnt0),
        .req1    (req1),
        .lock1   (lock1),
        .addr1   (addr1),
        .data1   (data1),
        .gnt1    (gnt1),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .sel     (sel),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        #1;
        chk({tag, "_gnt0"}, gnt0, g0);
        chk({tag, "_gnt1"}, gnt1, g1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 3'd1; addr1 = 3'd2; data0 = 16'd30; data1 = 16'd17;

        // Reset held with both ports requesting
        step(); step();
        chk_gnt("rst", 1'b0, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_data", wr_data, 16'd0);

        // Tie after reset: port 0 first, then port 1
        rst_n = 1'b1;
        chk_gnt("tie0", 1'b1, 1'b0);
        step();
        chk("tie0_wr_en", wr_en, 1'b1);
        chk("tie0_wr_data", wr_data, 16'd30);
        chk("tie0_wr_addr", wr_addr, 3'd1);
        chk("tie0_sel", sel, 1'b0);
        chk_gnt("tie1", 1'b0, 1'b1);
        step();
        chk("tie1_wr_data", wr_data, 16'd17);
        chk("tie1_sel", sel, 1'b1);

        // Single port 1 for three beats
        req0 = 1'b0; addr1 = 3'd5; data1 = 16'h00AA;
        for (int i = 0; i < 3; i++) begin
            chk_gnt("single", 1'b0, 1'b1);
            step();
            chk("single_wr_en", wr_en, 1'b1);
            chk("single_wr_addr", wr_addr, 3'd5);
            chk("single_wr_data", wr_data, 16'h00AA);
            chk("single_sel", sel, 1'b1);
        end
        req1 = 1'b0;
        chk_gnt("idle", 1'b0, 1'b0);
        step();
        chk("idle_wr_en", wr_en, 1'b0);
        chk("idle_wr_addr_hold", wr_addr, 3'd5);

        // Locked port-0 burst forced out after 4 beats by waiting port 1
        req0 = 1'b1; lock0 = 1'b1; addr0 = 3'd3; data0 = 16'h1234;
        req1 = 1'b1; lock1 = 1'b0; data1 = 16'h0BEE;
        for (int i = 0; i < 4; i++) begin
            chk_gnt("burst", 1'b1, 1'b0);
            step();
            chk("burst_wr_data", wr_data, 16'h1234);
            chk("burst_sel", sel, 1'b0);
            chk("burst_busy", busy, (i < 3) ? 1'b1 : 1'b0);
        end
        chk_gnt("release", 1'b0, 1'b1);
        step();
        chk("release_wr_data", wr_data, 16'h0BEE);
        chk("release_sel", sel, 1'b1);
        chk("release_busy", busy, 1'b0);

        // Owner drops its request mid-burst: port 1 takes the same cycle
        req1 = 1'b0;
        chk_gnt("drop_b1", 1'b1, 1'b0);
        step();
        chk("drop_busy1", busy, 1'b1);
        chk_gnt("drop_b2", 1'b1, 1'b0);
        step();
        req0 = 1'b0; req1 = 1'b1; lock1 = 1'b1; data1 = 16'h5A5A;
        chk_gnt("drop_sw", 1'b0, 1'b1);
        step();
        chk("drop_wr_data", wr_data, 16'h5A5A);
        chk("drop_sel", sel, 1'b1);
        chk("drop_own1_busy", busy, 1'b1);
        lock1 = 1'b0;
        chk_gnt("own1_end", 1'b0, 1'b1);
        step();
        chk("own1_end_busy", busy, 1'b0);

        // Reset during beat 2 of a port-0 burst; last was left at port 0
        req1 = 1'b0; req0 = 1'b1; lock0 = 1'b1; data0 = 16'hC0DE;
        chk_gnt("mid_b1", 1'b1, 1'b0);
        step();
        chk("mid_busy", busy, 1'b1);
        chk_gnt("mid_b2", 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_gnt0", gnt0, 1'b0);
        step();
        rst_n = 1'b1; req1 = 1'b1; lock0 = 1'b0;
        chk_gnt("post_rst_tie", 1'b1, 1'b0);
        step();
        chk("post_rst_wr_data", wr_data, 16'hC0DE);
        chk("post_rst_sel", sel, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_wb_port_arbiter
